// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: opaque payload with valid/ready handshake, flush,
// bubble payload, optional 2-entry skid mode and a saturating bubble counter.
module pipe_stage_buf #(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter bit               SKID_EN    = 1'b1,
  parameter int               CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_level,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             in_xfer, out_xfer;

  // The state encoding doubles as the entry count.
  assign o_valid      = (state_q != EMPTY);
  assign o_level      = 2'(state_q);
  assign o_data       = o_valid ? main_q : BUBBLE_VAL;
  assign o_ready      = SKID_EN ? ready_q : (!o_valid || i_ready);
  assign o_bubble_cnt = bubble_cnt_q;

  always_comb begin
    in_xfer      = i_valid && o_ready;
    out_xfer     = o_valid && i_ready;
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    bubble_cnt_d = bubble_cnt_q;

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = i_data;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = i_data;
        end else if (in_xfer) begin
          // Without skid, o_ready implies out_xfer here, so this is skid-only.
          if (SKID_EN) begin
            state_d = TWO;
            skid_d  = i_data;
          end
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (i_flush) state_d = EMPTY;

    ready_d = (state_d != TWO);

    if (!o_valid && (bubble_cnt_q != CNT_MAX)) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      ready_q      <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      ready_q      <= ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid instance, non-skid instance and a
// narrow-counter instance driven with directed vectors.
module tb_pipe_stage_buf;

  localparam logic [63:0] BUB = 64'h1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s_flush, s_valid, s_ready_o, s_ready_i, s_ovalid;
  logic [63:0] s_din, s_dout;
  logic [1:0]  s_level;
  logic [31:0] s_cnt;

  logic        z_flush, z_valid, z_ready_o, z_ready, z_ovalid;
  logic [63:0] z_din, z_dout;
  logic [1:0]  z_level;
  logic [31:0] z_cnt;

  logic        c_rst, c_flush, c_valid, c_ready_o, c_ready, c_ovalid;
  logic [63:0] c_din, c_dout;
  logic [1:0]  c_level;
  logic [2:0]  c_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] exp_q[$];

  pipe_stage_buf #(.WIDTH(64), .BUBBLE_VAL(BUB), .SKID_EN(1'b1), .CNT_W(32)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_flush(s_flush), .i_valid(s_valid), .o_ready(s_ready_o),
    .i_data(s_din), .o_valid(s_ovalid), .i_ready(s_ready_i), .o_data(s_dout),
    .o_level(s_level), .o_bubble_cnt(s_cnt));

  pipe_stage_buf #(.WIDTH(64), .BUBBLE_VAL(BUB), .SKID_EN(1'b0), .CNT_W(32)) dut_z (
    .i_clk(clk), .i_rst(rst), .i_flush(z_flush), .i_valid(z_valid), .o_ready(z_ready_o),
    .i_data(z_din), .o_valid(z_ovalid), .i_ready(z_ready), .o_data(z_dout),
    .o_level(z_level), .o_bubble_cnt(z_cnt));

  pipe_stage_buf #(.WIDTH(64), .BUBBLE_VAL(BUB), .SKID_EN(1'b1), .CNT_W(3)) dut_c (
    .i_clk(clk), .i_rst(c_rst), .i_flush(c_flush), .i_valid(c_valid), .o_ready(c_ready_o),
    .i_data(c_din), .o_valid(c_ovalid), .i_ready(c_ready), .o_data(c_dout),
    .o_level(c_level), .o_bubble_cnt(c_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one payload to dut_s and record it as expected once it is accepted.
  task automatic send(input logic [63:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_din   = d;
    @(negedge clk);
    while (!s_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: payload 0x%0h not accepted within 50 cycles", d);
    end else begin
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && s_ovalid && s_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no output", s_dout);
      end else begin
        chk("sb_data", s_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; c_rst = 1'b1;
    s_flush = 0; s_valid = 0; s_ready_i = 0; s_din = '0;
    z_flush = 0; z_valid = 0; z_ready = 0; z_din = '0;
    c_flush = 0; c_valid = 0; c_ready = 0; c_din = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", s_ovalid, 0);
    chk("rst_data", s_dout, BUB);
    chk("rst_ready", s_ready_o, 1);
    chk("rst_level", s_level, 0);
    chk("rst_cnt", s_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0; c_rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_valid", s_ovalid, 0);
    chk("idle_data", s_dout, BUB);
    chk("idle_ready", s_ready_o, 1);
    chk("idle_cnt5", s_cnt, 5);

    // Narrow counter saturation and async reset mid-cycle
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cnt_sat", c_cnt, 7);
    @(posedge clk); #1;
    c_valid = 1'b1; c_din = 64'hF0;
    @(posedge clk); #1;
    c_valid = 1'b0;
    @(negedge clk);
    chk("cnt_hold", c_cnt, 7);
    chk("c_loaded_valid", c_ovalid, 1);
    chk("c_loaded_data", c_dout, 64'hF0);
    @(posedge clk); #2;
    c_rst = 1'b1;
    #1;
    chk("arst_valid", c_ovalid, 0);
    chk("arst_level", c_level, 0);
    chk("arst_cnt", c_cnt, 0);
    chk("arst_data", c_dout, BUB);
    #1;
    c_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cnt_after_arst", c_cnt, 1);

    // Streaming with downstream always ready
    @(posedge clk); #1;
    s_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'hA0 + 64'(i));
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("stream_valid", s_ovalid, 1);
          chk("stream_level", s_level, 1);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Backpressure into the skid register
    s_ready_i = 1'b0;
    fork
      begin
        send(64'hB0); send(64'hB1); send(64'hB2);
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("skid_level", s_level, 2);
        chk("skid_ready", s_ready_o, 0);
        chk("skid_head", s_dout, 64'hB0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("skid_stall_level", s_level, 2);
        chk("skid_stall_ready", s_ready_o, 0);
        @(posedge clk); #1;
        s_ready_i = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_valid", s_ovalid, 0);

    // Flush colliding with an input in TWO, then in ONE
    @(posedge clk); #1;
    s_ready_i = 1'b0;
    send(64'hC0); send(64'hC1);
    exp_q.delete();
    s_flush = 1'b1; s_valid = 1'b1; s_din = 64'hC2;
    @(posedge clk); #1;
    s_flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("flush2_valid", s_ovalid, 0);
    chk("flush2_level", s_level, 0);
    chk("flush2_data", s_dout, BUB);
    chk("flush2_ready", s_ready_o, 1);
    @(posedge clk); #1;
    send(64'hE0);
    exp_q.delete();
    s_flush = 1'b1; s_valid = 1'b1; s_din = 64'hE1;
    @(negedge clk);
    chk("flush1_ready", s_ready_o, 1);
    @(posedge clk); #1;
    s_flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("flush1_valid", s_ovalid, 0);
    chk("flush1_level", s_level, 0);
    @(posedge clk); #1;
    s_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_no_leak", s_ovalid, 0);

    // Single-entry mode with combinational ready
    @(posedge clk); #1;
    z_valid = 1'b1; z_din = 64'hD0; z_ready = 1'b0;
    @(negedge clk);
    chk("nskid_ready_empty", z_ready_o, 1);
    @(posedge clk); #1;
    z_din = 64'hD1;
    @(negedge clk);
    chk("nskid_valid", z_ovalid, 1);
    chk("nskid_data0", z_dout, 64'hD0);
    chk("nskid_ready_blocked", z_ready_o, 0);
    @(posedge clk); #1;
    chk("nskid_hold_data", z_dout, 64'hD0);
    z_ready = 1'b1;
    #1;
    chk("nskid_ready_comb", z_ready_o, 1);
    @(posedge clk); #1;
    z_valid = 1'b0;
    @(negedge clk);
    chk("nskid_data1", z_dout, 64'hD1);
    chk("nskid_level", z_level, 1);
    @(posedge clk);
    @(negedge clk);
    chk("nskid_empty_valid", z_ovalid, 0);
    chk("nskid_empty_data", z_dout, BUB);

    @(negedge clk);
    chk("sb_leftover", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
